// File: rtl/frame_buffer_read_arbiter.sv
// rtl/frame_buffer_read_arbiter.sv - frame-buffer RAM read-port arbiter (display priority, processing fill)
//
// Shares one registered-output RAM read port between the display scanout and
// the image-processing engine. Display has fixed priority. Every grant issues
// one RAM read on the following cycle. Read data returns to the owner exactly
// 3 cycles after the grant, in grant order.
//
// Optional feature: define ARB_STARVE_GUARD_EN to force a processing slot
// after STARVE_LIMIT consecutive denied processing-request cycles.
//
// Ports:
//   clk_i, rst_ni                       read-domain clock, sync active-low reset
//   disp_req_i/addr_i, disp_gnt_o       display request/address, combinational grant
//   disp_valid_o, disp_data_o           display read return (registered)
//   proc_req_i/addr_i, proc_gnt_o       processing request/address, combinational grant
//   proc_valid_o, proc_data_o           processing read return (registered)
//   ram_read_en_o, ram_read_address_o   RAM read command (registered)
//   ram_read_data_i                     RAM data, valid one cycle after read enable
//   oob_err_o                           sticky: out-of-range address was granted
module frame_buffer_read_arbiter #(
  parameter int WIDTH        = 12,
  parameter int DEPTH        = 76800,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     disp_req_i,
  input  logic [$clog2(DEPTH)-1:0] disp_addr_i,
  output logic                     disp_gnt_o,
  output logic                     disp_valid_o,
  output logic [WIDTH-1:0]         disp_data_o,
  input  logic                     proc_req_i,
  input  logic [$clog2(DEPTH)-1:0] proc_addr_i,
  output logic                     proc_gnt_o,
  output logic                     proc_valid_o,
  output logic [WIDTH-1:0]         proc_data_o,
  output logic                     ram_read_en_o,
  output logic [$clog2(DEPTH)-1:0] ram_read_address_o,
  input  logic [WIDTH-1:0]         ram_read_data_i,
  output logic                     oob_err_o
);

  localparam int AW = $clog2(DEPTH);

  logic             force_proc;
  logic             any_gnt;
  logic [AW-1:0]    sel_addr;
  logic             sel_oob;
  logic [WIDTH-1:0] ret_data;

  logic             ram_en_d,     ram_en_q;
  logic [AW-1:0]    ram_addr_d,   ram_addr_q;
  // Tag pipeline: stage 1 lines up with the RAM command, stage 2 with RAM data.
  logic             t1_vld_d,     t1_vld_q;
  logic             t1_own_d,     t1_own_q;   // 1 = processing owns the read
  logic             t1_oob_d,     t1_oob_q;
  logic             t2_vld_d,     t2_vld_q;
  logic             t2_own_d,     t2_own_q;
  logic             t2_oob_d,     t2_oob_q;
  logic             disp_valid_d, disp_valid_q;
  logic [WIDTH-1:0] disp_data_d,  disp_data_q;
  logic             proc_valid_d, proc_valid_q;
  logic [WIDTH-1:0] proc_data_d,  proc_data_q;
  logic             oob_d,        oob_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_d, starve_q;
`endif

  always_comb begin
    force_proc = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    force_proc = proc_req_i && (starve_q == SW'(STARVE_LIMIT));
`endif

    // Grants are gated by reset so nothing is accepted while the pipeline is held clear.
    disp_gnt_o = rst_ni && disp_req_i && !force_proc;
    proc_gnt_o = rst_ni && proc_req_i && !disp_gnt_o;
    any_gnt    = disp_gnt_o || proc_gnt_o;

    sel_addr = proc_gnt_o ? proc_addr_i : disp_addr_i;
    // Compare at 32 bits so a power-of-two DEPTH cannot truncate to zero.
    sel_oob  = (32'(sel_addr) >= 32'(DEPTH));

    // An out-of-range grant still occupies a tag slot but never touches the RAM.
    ram_en_d   = any_gnt && !sel_oob;
    ram_addr_d = ram_en_d ? sel_addr : ram_addr_q;

    t1_vld_d = any_gnt;
    t1_own_d = proc_gnt_o;
    t1_oob_d = sel_oob;
    t2_vld_d = t1_vld_q;
    t2_own_d = t1_own_q;
    t2_oob_d = t1_oob_q;

    ret_data     = t2_oob_q ? '0 : ram_read_data_i;
    disp_valid_d = t2_vld_q && !t2_own_q;
    proc_valid_d = t2_vld_q &&  t2_own_q;
    disp_data_d  = disp_valid_d ? ret_data : disp_data_q;
    proc_data_d  = proc_valid_d ? ret_data : proc_data_q;

    oob_d = oob_q || (any_gnt && sel_oob);

`ifdef ARB_STARVE_GUARD_EN
    if (!proc_req_i || proc_gnt_o) begin
      starve_d = '0;
    end else if (starve_q == SW'(STARVE_LIMIT)) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ram_en_q     <= 1'b0;
      ram_addr_q   <= '0;
      t1_vld_q     <= 1'b0;
      t1_own_q     <= 1'b0;
      t1_oob_q     <= 1'b0;
      t2_vld_q     <= 1'b0;
      t2_own_q     <= 1'b0;
      t2_oob_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      proc_valid_q <= 1'b0;
      proc_data_q  <= '0;
      oob_q        <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q     <= '0;
`endif
    end else begin
      ram_en_q     <= ram_en_d;
      ram_addr_q   <= ram_addr_d;
      t1_vld_q     <= t1_vld_d;
      t1_own_q     <= t1_own_d;
      t1_oob_q     <= t1_oob_d;
      t2_vld_q     <= t2_vld_d;
      t2_own_q     <= t2_own_d;
      t2_oob_q     <= t2_oob_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      proc_valid_q <= proc_valid_d;
      proc_data_q  <= proc_data_d;
      oob_q        <= oob_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q     <= starve_d;
`endif
    end
  end

  assign ram_read_en_o      = ram_en_q;
  assign ram_read_address_o = ram_addr_q;
  assign disp_valid_o       = disp_valid_q;
  assign disp_data_o        = disp_data_q;
  assign proc_valid_o       = proc_valid_q;
  assign proc_data_o        = proc_data_q;
  assign oob_err_o          = oob_q;

endmodule

// File: tb/tb_frame_buffer_read_arbiter.sv
// tb/tb_frame_buffer_read_arbiter.sv - directed self-checking bench for frame_buffer_read_arbiter
module tb_frame_buffer_read_arbiter;

  localparam int WIDTH = 12;
  localparam int DEPTH = 76800;
  localparam int AW    = $clog2(DEPTH);

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             disp_req_i = 1'b0;
  logic [AW-1:0]    disp_addr_i = '0;
  logic             disp_gnt_o;
  logic             disp_valid_o;
  logic [WIDTH-1:0] disp_data_o;
  logic             proc_req_i = 1'b0;
  logic [AW-1:0]    proc_addr_i = '0;
  logic             proc_gnt_o;
  logic             proc_valid_o;
  logic [WIDTH-1:0] proc_data_o;
  logic             ram_read_en_o;
  logic [AW-1:0]    ram_read_address_o;
  logic [WIDTH-1:0] ram_read_data_i = '0;
  logic             oob_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  frame_buffer_read_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i), .disp_gnt_o(disp_gnt_o),
    .disp_valid_o(disp_valid_o), .disp_data_o(disp_data_o),
    .proc_req_i(proc_req_i), .proc_addr_i(proc_addr_i), .proc_gnt_o(proc_gnt_o),
    .proc_valid_o(proc_valid_o), .proc_data_o(proc_data_o),
    .ram_read_en_o(ram_read_en_o), .ram_read_address_o(ram_read_address_o),
    .ram_read_data_i(ram_read_data_i), .oob_err_o(oob_err_o)
  );

  always #5 clk_i = ~clk_i;

  // RAM contents: word(a) = a[11:0] ^ 12'h5A5, registered read.
  function automatic logic [WIDTH-1:0] word(input logic [AW-1:0] a);
    return a[WIDTH-1:0] ^ 12'h5A5;
  endfunction

  always @(posedge clk_i) begin
    if (ram_read_en_o) ram_read_data_i <= word(ram_read_address_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    disp_req_i = 1'b0;
    proc_req_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ram_en"},     32'(ram_read_en_o),      32'h0);
    check({tag, ".ram_addr"},   32'(ram_read_address_o), 32'h0);
    check({tag, ".disp_valid"}, 32'(disp_valid_o),       32'h0);
    check({tag, ".disp_data"},  32'(disp_data_o),        32'h0);
    check({tag, ".proc_valid"}, 32'(proc_valid_o),       32'h0);
    check({tag, ".proc_data"},  32'(proc_data_o),        32'h0);
    check({tag, ".oob"},        32'(oob_err_o),          32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int after_d;
    int after_p;
    int exp_first;
    int vcount;

    // Reset state
    step();
    step();
    check_all_zero("rst");
    rst_ni = 1'b1;

    // Test 1: display-only back-to-back reads of 0, 1, 2
    disp_req_i = 1'b1; disp_addr_i = 17'd0; #1;
    check("t1.gnt0", 32'(disp_gnt_o), 32'h1);
    check("t1.pgnt0", 32'(proc_gnt_o), 32'h0);
    step();
    check("t1.en1", 32'(ram_read_en_o), 32'h1);
    check("t1.addr1", 32'(ram_read_address_o), 32'h0);
    disp_addr_i = 17'd1; #1;
    check("t1.gnt1", 32'(disp_gnt_o), 32'h1);
    step();
    check("t1.addr2", 32'(ram_read_address_o), 32'h1);
    check("t1.dv2", 32'(disp_valid_o), 32'h0);
    disp_addr_i = 17'd2;
    step();
    check("t1.en3", 32'(ram_read_en_o), 32'h1);
    check("t1.addr3", 32'(ram_read_address_o), 32'h2);
    check("t1.dv3", 32'(disp_valid_o), 32'h1);
    check("t1.dd3", 32'(disp_data_o), 32'h5A5);
    disp_req_i = 1'b0;
    step();
    check("t1.en4", 32'(ram_read_en_o), 32'h0);
    check("t1.dd4", 32'(disp_data_o), 32'h5A4);
    step();
    check("t1.dv5", 32'(disp_valid_o), 32'h1);
    check("t1.dd5", 32'(disp_data_o), 32'h5A7);
    check("t1.pv5", 32'(proc_valid_o), 32'h0);
    step();
    check("t1.dv6", 32'(disp_valid_o), 32'h0);
    check("t1.hold6", 32'(disp_data_o), 32'h5A7);

    // Test 2: simultaneous requests, display first
    disp_req_i = 1'b1; disp_addr_i = 17'd10;
    proc_req_i = 1'b1; proc_addr_i = 17'd20; #1;
    check("t2.dgnt", 32'(disp_gnt_o), 32'h1);
    check("t2.pgnt", 32'(proc_gnt_o), 32'h0);
    step();
    disp_req_i = 1'b0; #1;
    check("t2.pgnt1", 32'(proc_gnt_o), 32'h1);
    check("t2.addr1", 32'(ram_read_address_o), 32'd10);
    step();
    proc_req_i = 1'b0;
    check("t2.addr2", 32'(ram_read_address_o), 32'd20);
    step();
    check("t2.dv3", 32'(disp_valid_o), 32'h1);
    check("t2.dd3", 32'(disp_data_o), 32'h5AF);
    check("t2.pv3", 32'(proc_valid_o), 32'h0);
    step();
    check("t2.pv4", 32'(proc_valid_o), 32'h1);
    check("t2.pd4", 32'(proc_data_o), 32'h5B1);
    check("t2.dv4", 32'(disp_valid_o), 32'h0);
    step();

    // Test 3: starvation behaviour under continuous display traffic
    disp_req_i = 1'b1; disp_addr_i = 17'd100;
    proc_req_i = 1'b1; proc_addr_i = 17'd5;
    first = -1; after_d = -1; after_p = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (first >= 0 && i == first + 1) begin
        after_d = int'(disp_gnt_o);
        after_p = int'(proc_gnt_o);
      end
      if (proc_gnt_o && first < 0) first = i;
      step();
      if (i == first) proc_req_i = 1'b0;
    end
`ifdef ARB_STARVE_GUARD_EN
    exp_first = 8;
    check("t3.after_dgnt", 32'(after_d), 32'h1);
    check("t3.after_pgnt", 32'(after_p), 32'h0);
`else
    exp_first = -1;
`endif
    check("t3.first_pgnt", 32'(first), 32'(exp_first));
    disp_req_i = 1'b0; proc_req_i = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Test 5: last legal address
    do_reset();
    proc_req_i = 1'b1; proc_addr_i = 17'd76799; #1;
    check("t5.gnt", 32'(proc_gnt_o), 32'h1);
    step();
    proc_req_i = 1'b0;
    check("t5.en", 32'(ram_read_en_o), 32'h1);
    check("t5.addr", 32'(ram_read_address_o), 32'd76799);
    check("t5.oob1", 32'(oob_err_o), 32'h0);
    step();
    step();
    check("t5.pv", 32'(proc_valid_o), 32'h1);
    check("t5.pd", 32'(proc_data_o), 32'hE5A);
    check("t5.oob3", 32'(oob_err_o), 32'h0);
    step();

    // Test 4: out-of-range address
    proc_req_i = 1'b1; proc_addr_i = 17'd76800; #1;
    check("t4.gnt", 32'(proc_gnt_o), 32'h1);
    step();
    proc_req_i = 1'b0;
    check("t4.en", 32'(ram_read_en_o), 32'h0);
    check("t4.oob1", 32'(oob_err_o), 32'h1);
    step();
    check("t4.pv2", 32'(proc_valid_o), 32'h0);
    step();
    check("t4.pv3", 32'(proc_valid_o), 32'h1);
    check("t4.pd3", 32'(proc_data_o), 32'h0);
    step(); step(); step();
    check("t4.oob_sticky", 32'(oob_err_o), 32'h1);

    // Test 6: reset one cycle after a grant
    disp_req_i = 1'b1; disp_addr_i = 17'd7; #1;
    check("t6.gnt", 32'(disp_gnt_o), 32'h1);
    step();
    rst_ni = 1'b0; proc_req_i = 1'b1; #1;
    check("t6.rst_dgnt", 32'(disp_gnt_o), 32'h0);
    check("t6.rst_pgnt", 32'(proc_gnt_o), 32'h0);
    step();
    check_all_zero("t6.rst");
    step();
    check("t6.rst2_dv", 32'(disp_valid_o), 32'h0);
    rst_ni = 1'b1; disp_req_i = 1'b0; proc_req_i = 1'b0;
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (disp_valid_o || proc_valid_o) vcount++;
    end
    check("t6.no_ghost", 32'(vcount), 32'h0);
    disp_req_i = 1'b1; disp_addr_i = 17'd9; #1;
    check("t6.gnt_post", 32'(disp_gnt_o), 32'h1);
    step();
    disp_req_i = 1'b0;
    step();
    check("t6.dv2", 32'(disp_valid_o), 32'h0);
    step();
    check("t6.dv3", 32'(disp_valid_o), 32'h1);
    check("t6.dd3", 32'(disp_data_o), 32'h5AC);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
